// File: rtl/threshold_stream.sv
// Registered valid/ready thresholding stage between the DWT and RLE.
// Hard/soft dead zone, frame-aligned threshold updates, per-frame zero count.
module threshold_stream #(
   parameter int WIDTH   = 9,
   parameter int CNT_W   = 10,
   parameter int THR_RST = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    thr_load,
   input  logic [WIDTH-2:0]        thr_in,
   input  logic                    mode_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_data,
   output logic                    out_last,
   output logic [CNT_W-1:0]        zero_cnt,
   output logic                    cnt_valid
);

   typedef enum logic {IDLE, FRAME} state_t;

   state_t                  state;
   logic [WIDTH-2:0]        thr;
   logic [WIDTH-2:0]        pend_thr;
   logic                    mode;
   logic                    pend_mode;
   logic                    pend;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_nxt;
   logic                    xfer;
   logic                    idle;
   logic                    zeroed;
   logic                    take_pend;
   logic signed [WIDTH:0]   xe;
   logic [WIDTH:0]          mag;
   logic [WIDTH:0]          thr_ext;
   logic signed [WIDTH-1:0] thr_w;
   logic signed [WIDTH-1:0] res;

   assign in_ready = !out_valid || out_ready;
   assign xfer     = in_valid && in_ready;
   assign idle     = (state == IDLE);

   // One extra bit keeps |-2^(WIDTH-1)| representable.
   always_comb begin
      xe      = {in_data[WIDTH-1], in_data};
      mag     = xe[WIDTH] ? $unsigned(-xe) : $unsigned(xe);
      thr_ext = {2'b00, thr};
      thr_w   = $signed({1'b0, thr});
      zeroed  = (mag <= thr_ext);
      if (zeroed)
         res = '0;
      else if (!mode)
         res = in_data;
      else if (in_data[WIDTH-1])
         res = in_data + thr_w;
      else
         res = in_data - thr_w;
   end

   always_comb begin
      cnt_nxt = cnt;
      if (zeroed && (cnt != '1))
         cnt_nxt = cnt + CNT_W'(1);
   end

   assign take_pend = pend && ((xfer && in_last) || (idle && !xfer));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         thr       <= (WIDTH-1)'(THR_RST);
         mode      <= 1'b0;
         pend_thr  <= '0;
         pend_mode <= 1'b0;
         pend      <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         zero_cnt  <= '0;
         cnt_valid <= 1'b0;
      end else begin
         cnt_valid <= 1'b0;

         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_last  <= in_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (xfer) begin
            if (in_last) begin
               zero_cnt  <= cnt_nxt;
               cnt_valid <= 1'b1;
               cnt       <= '0;
               state     <= IDLE;
            end else begin
               cnt   <= cnt_nxt;
               state <= FRAME;
            end
         end

         // Threshold only moves between frames; otherwise it waits in pend.
         if (thr_load && idle && !xfer) begin
            thr  <= thr_in;
            mode <= mode_in;
            pend <= 1'b0;
         end else begin
            if (take_pend) begin
               thr  <= pend_thr;
               mode <= pend_mode;
               pend <= 1'b0;
            end
            if (thr_load) begin
               pend_thr  <= thr_in;
               pend_mode <= mode_in;
               pend      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_threshold_stream.sv
// Directed self-checking bench for threshold_stream.
// Second instance with a 3-bit counter covers zero-count saturation.
module tb_threshold_stream;

   logic              clk = 1'b0;
   logic              rst;
   logic              thr_load;
   logic [7:0]        thr_in;
   logic              mode_in;
   logic              in_valid;
   logic              in_ready;
   logic signed [8:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic signed [8:0] out_data;
   logic              out_last;
   logic [9:0]        zero_cnt;
   logic              cnt_valid;

   logic              in_ready3;
   logic              out_valid3;
   logic signed [8:0] out_data3;
   logic              out_last3;
   logic [2:0]        zero_cnt3;
   logic              cnt_valid3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   threshold_stream #(.WIDTH(9), .CNT_W(10), .THR_RST(1)) dut (
      .clk(clk), .rst(rst), .thr_load(thr_load), .thr_in(thr_in),
      .mode_in(mode_in), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .zero_cnt(zero_cnt), .cnt_valid(cnt_valid)
   );

   threshold_stream #(.WIDTH(9), .CNT_W(3), .THR_RST(1)) dut3 (
      .clk(clk), .rst(rst), .thr_load(thr_load), .thr_in(thr_in),
      .mode_in(mode_in), .in_valid(in_valid), .in_ready(in_ready3),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid3),
      .out_ready(out_ready), .out_data(out_data3), .out_last(out_last3),
      .zero_cnt(zero_cnt3), .cnt_valid(cnt_valid3)
   );

   // One beat with out_ready high; returns just after the accepting edge.
   task automatic send(input logic signed [8:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic load(input logic [7:0] t, input logic m);
      thr_load = 1'b1;
      thr_in   = t;
      mode_in  = m;
      @(posedge clk);
      #1;
      thr_load = 1'b0;
   endtask

   function automatic logic signed [8:0] hard_ref(input logic signed [8:0] x,
                                                  input int t);
      int a;
      a = (x < 0) ? -int'(x) : int'(x);
      return (a <= t) ? 9'sd0 : x;
   endfunction

   task automatic test_reset;
      rst = 1'b1; thr_load = 1'b0; thr_in = '0; mode_in = 1'b0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if ({in_ready, out_valid, out_data, out_last, zero_cnt, cnt_valid}
          !== {1'b1, 1'b0, 9'd0, 1'b0, 10'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: rdy=%b ov=%b od=%0d ol=%b zc=%0d cv=%b req 1 0 0 0 0 0",
                  in_ready, out_valid, out_data, out_last, zero_cnt, cnt_valid);
      end
   endtask

   task automatic test_hard_default;
      logic signed [8:0] exp_d [7];
      exp_d = '{-9'sd3, -9'sd2, 9'sd0, 9'sd0, 9'sd0, 9'sd2, 9'sd3};
      for (int i = 0; i < 7; i++) begin
         send(9'(i - 3), (i == 6));
         n_checks++;
         if (!out_valid || out_data !== exp_d[i] || out_last !== (i == 6)) begin
            n_fail++;
            $display("FAIL hard_default[%0d]: got v=%b d=%0d l=%b req d=%0d",
                     i, out_valid, out_data, out_last, exp_d[i]);
         end
      end
      n_checks++;
      if (cnt_valid !== 1'b1 || zero_cnt !== 10'd3) begin
         n_fail++;
         $display("FAIL hard_count: cv=%b zc=%0d req 1 3", cnt_valid, zero_cnt);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (cnt_valid !== 1'b0 || out_valid !== 1'b0 || zero_cnt !== 10'd3) begin
         n_fail++;
         $display("FAIL hard_after: cv=%b ov=%b zc=%0d req 0 0 3",
                  cnt_valid, out_valid, zero_cnt);
      end
   endtask

   task automatic test_soft;
      logic signed [8:0] din [4];
      logic signed [8:0] dex [4];
      din = '{9'sd10, -9'sd10, 9'sd4, -9'sd256};
      dex = '{9'sd6, -9'sd6, 9'sd0, -9'sd252};
      load(8'd4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send(din[i], (i == 3));
         n_checks++;
         if (!out_valid || out_data !== dex[i]) begin
            n_fail++;
            $display("FAIL soft[%0d]: got v=%b d=%0d req %0d",
                     i, out_valid, out_data, dex[i]);
         end
      end
      n_checks++;
      if (cnt_valid !== 1'b1 || zero_cnt !== 10'd1) begin
         n_fail++;
         $display("FAIL soft_count: cv=%b zc=%0d req 1 1", cnt_valid, zero_cnt);
      end
   endtask

   task automatic test_midframe_load;
      load(8'd1, 1'b0);
      send(9'sd1, 1'b0);
      n_checks++;
      if (out_data !== 9'sd0) begin
         n_fail++;
         $display("FAIL midload_0: got %0d req 0", out_data);
      end
      load(8'd0, 1'b0);
      send(9'sd1, 1'b0);
      n_checks++;
      if (!out_valid || out_data !== 9'sd0) begin
         n_fail++;
         $display("FAIL midload_1: got v=%b d=%0d req 0", out_valid, out_data);
      end
      send(9'sd1, 1'b1);
      n_checks++;
      if (out_data !== 9'sd0 || zero_cnt !== 10'd3 || !cnt_valid) begin
         n_fail++;
         $display("FAIL midload_2: got d=%0d zc=%0d cv=%b req 0 3 1",
                  out_data, zero_cnt, cnt_valid);
      end
      send(9'sd1, 1'b1);
      n_checks++;
      if (out_data !== 9'sd1 || zero_cnt !== 10'd0) begin
         n_fail++;
         $display("FAIL midload_new: got d=%0d zc=%0d req 1 0", out_data, zero_cnt);
      end
   endtask

   task automatic test_backpressure;
      logic signed [8:0] vin [100];
      logic signed [8:0] vex [100];
      int                exp_zc = 0;
      int                sent = 0, recv = 0, cyc = 0, pulses = 0;
      logic              p_stall = 1'b0;
      logic signed [8:0] p_data = '0;
      logic              p_last = 1'b0;
      load(8'd2, 1'b0);
      for (int i = 0; i < 100; i++) begin
         vin[i] = 9'(((i * 37) % 19) - 9);
         vex[i] = hard_ref(vin[i], 2);
         if (vex[i] == 0) exp_zc++;
      end
      while (recv < 100 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (p_stall) begin
            n_checks++;
            if (!out_valid || out_data !== p_data || out_last !== p_last) begin
               n_fail++;
               $display("FAIL bp_hold: got v=%b d=%0d l=%b req 1 %0d %b",
                        out_valid, out_data, out_last, p_data, p_last);
            end
         end
         if (cnt_valid) begin
            pulses++;
            n_checks++;
            if (zero_cnt !== 10'(exp_zc)) begin
               n_fail++;
               $display("FAIL bp_count: got %0d req %0d", zero_cnt, exp_zc);
            end
         end
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (sent < 100);
         in_data   = (sent < 100) ? vin[sent] : 9'sd0;
         in_last   = (sent == 99);
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (out_data !== vex[recv] || out_last !== (recv == 99)) begin
               n_fail++;
               $display("FAIL bp_data[%0d]: got d=%0d l=%b req d=%0d l=%b",
                        recv, out_data, out_last, vex[recv], (recv == 99));
            end
            recv++;
         end
         if (in_valid && in_ready) sent++;
         p_stall = out_valid && !out_ready;
         p_data  = out_data;
         p_last  = out_last;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (cnt_valid) pulses++;
      end
      n_checks++;
      if (cyc >= 2000) begin
         n_fail++;
         $display("FAIL bp_timeout: received %0d of 100", recv);
      end
      n_checks++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL bp_pulses: got %0d req 1", pulses);
      end
      #1;
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 12; i++) send(9'sd0, (i == 11));
      n_checks++;
      if (zero_cnt3 !== 3'd7 || !cnt_valid3) begin
         n_fail++;
         $display("FAIL sat_cnt3: got %0d cv=%b req 7 1", zero_cnt3, cnt_valid3);
      end
      n_checks++;
      if (zero_cnt !== 10'd12) begin
         n_fail++;
         $display("FAIL sat_cnt10: got %0d req 12", zero_cnt);
      end
      send(9'sd0, 1'b0);
      send(9'sd5, 1'b1);
      n_checks++;
      if (zero_cnt3 !== 3'd1 || out_data3 !== 9'sd5) begin
         n_fail++;
         $display("FAIL sat_next: got zc=%0d d=%0d req 1 5", zero_cnt3, out_data3);
      end
   endtask

   task automatic test_reset_midframe;
      logic signed [8:0] din [4];
      logic signed [8:0] dex [4];
      int                pulses = 0;
      din = '{9'sd1, 9'sd2, -9'sd1, 9'sd5};
      dex = '{9'sd0, 9'sd2, 9'sd0, 9'sd5};
      for (int i = 0; i < 5; i++) send(9'sd0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if ({in_ready, out_valid, out_data, out_last, zero_cnt, cnt_valid}
          !== {1'b1, 1'b0, 9'd0, 1'b0, 10'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_mid: rdy=%b ov=%b od=%0d ol=%b zc=%0d cv=%b req 1 0 0 0 0 0",
                  in_ready, out_valid, out_data, out_last, zero_cnt, cnt_valid);
      end
      for (int i = 0; i < 4; i++) begin
         send(din[i], (i == 3));
         if (cnt_valid && i != 3) pulses++;
         n_checks++;
         if (out_data !== dex[i]) begin
            n_fail++;
            $display("FAIL rst_frame[%0d]: got %0d req %0d", i, out_data, dex[i]);
         end
      end
      n_checks++;
      if (zero_cnt !== 10'd2 || !cnt_valid || pulses != 0) begin
         n_fail++;
         $display("FAIL rst_count: got zc=%0d cv=%b early=%0d req 2 1 0",
                  zero_cnt, cnt_valid, pulses);
      end
   endtask

   initial begin
      test_reset;
      test_hard_default;
      test_soft;
      test_midframe_load;
      test_backpressure;
      test_saturation;
      test_reset_midframe;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
